// File: rtl/vga_frame_reader.sv
// Frame-buffer reader: register file + single-outstanding read master + word FIFO + BPP-bit pixel unpacker.
// Latency: word accepted in cycle N shows on pix_data in cycle N+2 (FIFO empty); one pixel/clock sustained.
// Backpressure: pix_ready low stalls the unpacker, the FIFO fills, and reads stop at FIFO_DEPTH words.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-low reset
//   avs_s1_*              Avalon-MM slave: 0 S_ADDR, 1 LENGTH, 2 CONTROL{IE,CONT,RUN},
//                         3 STATUS{DONE(w1c),BUSY}, 4 FILL, 5-7 read as zero
//   avm_read_*            Avalon-MM read master, one request at a time, byte addresses
//   pix_valid/ready/data  pixel stream, LSB-first within each fetched word
// Optional feature: define VGA_FRAME_IRQ_EN to drive avs_s1_irq from DONE && CONTROL.IE.

module vga_frame_reader #(
    parameter int DATA_W     = 16,
    parameter int BPP        = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              avs_s1_chipselect,
    input  logic [2:0]        avs_s1_address,
    input  logic              avs_s1_read,
    input  logic              avs_s1_write,
    input  logic [31:0]       avs_s1_writedata,
    input  logic [3:0]        avs_s1_byteenable,
    output logic [31:0]       avs_s1_readdata,
    output logic              avs_s1_waitrequest,
    output logic              avs_s1_irq,
    output logic [ADDR_W-1:0] avm_read_address,
    output logic              avm_read_read,
    input  logic [DATA_W-1:0] avm_read_readdata,
    input  logic              avm_read_waitrequest,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [BPP-1:0]    pix_data
);

    localparam int PPW   = DATA_W / BPP;          // pixels per word
    localparam int PW    = $clog2(PPW);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam int BYTES = DATA_W / 8;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_t;

    typedef struct packed {
        logic ie;
        logic cont;
        logic run;
    } ctrl_t;

    state_t state_q, state_d;

    logic [31:0]       s_addr_q;
    logic [31:0]       length_q;
    ctrl_t             ctrl_q;
    logic              done_q;
    logic [ADDR_W-1:0] work_addr_q;
    logic [31:0]       remaining_q;
    logic              rd_pend_q;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     fifo_count_q;

    logic [DATA_W-1:0] shift_q;
    logic [PW-1:0]     pix_cnt_q;
    logic              pix_valid_q;

    logic wr_en, start, push, pop, last_pix, drained;
    logic [31:0] reg_mux;

    function automatic logic [31:0] merge_be(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[b*8 +: 8] = be[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return r;
    endfunction

    assign wr_en    = avs_s1_chipselect && avs_s1_write;
    assign start    = wr_en && (avs_s1_address == 3'd2) && avs_s1_byteenable[0]
                      && avs_s1_writedata[0] && (state_q == S_IDLE);
    assign push     = avm_read_read && !avm_read_waitrequest;
    assign last_pix = (pix_cnt_q == PW'(PPW - 1));
    // Refill the unpacker when it is empty or its last pixel leaves this cycle.
    assign pop      = (fifo_count_q != '0) && (!pix_valid_q || (pix_ready && last_pix));
    assign drained  = (fifo_count_q == '0) && !pix_valid_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start && length_q != 32'd0) state_d = S_REQ;
            end
            S_REQ: begin
                if ((push && remaining_q == 32'd1) || remaining_q == 32'd0)
                    state_d = S_DRAIN;
                // A stop lets a stalled request complete before leaving.
                else if (!ctrl_q.run && !(avm_read_read && avm_read_waitrequest))
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (drained) state_d = (ctrl_q.run && ctrl_q.cont) ? S_REQ : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        avm_read_read = 1'b0;
        if (state_q == S_REQ && fifo_count_q < CW'(FIFO_DEPTH) && remaining_q != 32'd0
            && (ctrl_q.run || rd_pend_q))
            avm_read_read = 1'b1;
    end

    assign avm_read_address   = work_addr_q;
    assign avs_s1_waitrequest = 1'b0;
    assign pix_valid          = pix_valid_q;
    assign pix_data           = shift_q[BPP-1:0];

    // ---------------- registers, pointers, master bookkeeping ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            s_addr_q    <= '0;
            length_q    <= '0;
            ctrl_q      <= '0;
            done_q      <= 1'b0;
            work_addr_q <= '0;
            remaining_q <= '0;
            rd_pend_q   <= 1'b0;
        end else begin
            rd_pend_q <= avm_read_read && avm_read_waitrequest;

            if (wr_en) begin
                case (avs_s1_address)
                    3'd0: s_addr_q <= merge_be(s_addr_q, avs_s1_writedata, avs_s1_byteenable);
                    3'd1: length_q <= merge_be(length_q, avs_s1_writedata, avs_s1_byteenable);
                    3'd2: if (avs_s1_byteenable[0]) begin
                        ctrl_q.run  <= avs_s1_writedata[0];
                        ctrl_q.cont <= avs_s1_writedata[1];
`ifdef VGA_FRAME_IRQ_EN
                        ctrl_q.ie   <= avs_s1_writedata[2];
`endif
                    end
                    3'd3: if (avs_s1_byteenable[0] && avs_s1_writedata[1]) done_q <= 1'b0;
                    default: ;
                endcase
            end

            if (start) begin
                work_addr_q <= ADDR_W'(s_addr_q);
                remaining_q <= length_q;
                // Empty frame completes immediately without touching memory.
                if (length_q == 32'd0) begin
                    done_q     <= 1'b1;
                    ctrl_q.run <= 1'b0;
                end
            end

            if (push) begin
                work_addr_q <= work_addr_q + ADDR_W'(BYTES);
                remaining_q <= remaining_q - 32'd1;
            end

            // Frame end: DONE only for a frame that ran to completion (RUN still set).
            if (state_q == S_DRAIN && drained) begin
                if (ctrl_q.run) done_q <= 1'b1;
                if (ctrl_q.run && ctrl_q.cont) begin
                    work_addr_q <= ADDR_W'(s_addr_q);
                    remaining_q <= length_q;
                end else begin
                    ctrl_q.run <= 1'b0;
                end
            end
        end
    end

    // ---------------- word FIFO ----------------
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= avm_read_readdata;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count_q <= fifo_count_q + CW'(1);
                2'b01:   fifo_count_q <= fifo_count_q - CW'(1);
                default: fifo_count_q <= fifo_count_q;
            endcase
        end
    end

    // ---------------- pixel unpacker ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            shift_q     <= '0;
            pix_cnt_q   <= '0;
            pix_valid_q <= 1'b0;
        end else if (pop) begin
            shift_q     <= fifo_mem[rd_ptr_q];
            pix_cnt_q   <= '0;
            pix_valid_q <= 1'b1;
        end else if (pix_valid_q && pix_ready) begin
            if (last_pix) begin
                pix_valid_q <= 1'b0;
            end else begin
                shift_q   <= shift_q >> BPP;
                pix_cnt_q <= pix_cnt_q + PW'(1);
            end
        end
    end

    // ---------------- register read mux ----------------
    always_comb begin
        reg_mux = '0;
        case (avs_s1_address)
            3'd0:    reg_mux = s_addr_q;
            3'd1:    reg_mux = length_q;
            3'd2:    reg_mux = {29'd0, ctrl_q};
            3'd3:    reg_mux = {30'd0, done_q, state_q != S_IDLE};
            3'd4:    reg_mux = 32'(fifo_count_q);
            default: reg_mux = '0;
        endcase
        avs_s1_readdata = (avs_s1_chipselect && avs_s1_read) ? reg_mux : 32'd0;
    end

`ifdef VGA_FRAME_IRQ_EN
    assign avs_s1_irq = done_q && ctrl_q.ie;
`else
    assign avs_s1_irq = 1'b0;
`endif

endmodule

// File: doc/vga_frame_reader.md
# vga_frame_reader

Parametrised frame-buffer reader for the VGA path: an Avalon-MM slave register file, a single-outstanding Avalon-MM read master that fetches DATA_W-bit words from SDRAM into an internal FIFO, and a BPP-bit pixel unpacker with valid/ready output toward the pixel-clock crossing FIFO. It generalises the 1-bit reader to 1/2/4/8 bits per pixel, configurable word width and FIFO depth, and adds continuous (looping) frame mode with a done status.

## Interface
Parameters:
- DATA_W, 16, master read data width (16 or 32)
- BPP, 1, bits per pixel (1, 2, 4, 8; must divide DATA_W)
- FIFO_DEPTH, 16, word FIFO depth (power of 2, ≥4)
- ADDR_W, 32, master address width

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- avs_s1_chipselect  in  1  slave select
- avs_s1_address  in  3  register index
- avs_s1_read  in  1  register read strobe
- avs_s1_write  in  1  register write strobe
- avs_s1_writedata  in  32  write data
- avs_s1_byteenable  in  4  byte enables (bytes with 0 not written)
- avs_s1_readdata  out  32  register read data
- avs_s1_waitrequest  out  1  tied 0
- avs_s1_irq  out  1  frame-done interrupt (see Configuration)
- avm_read_address  out  ADDR_W  byte address of current word
- avm_read_read  out  1  read request
- avm_read_readdata  in  DATA_W  read data, valid when read && !waitrequest
- avm_read_waitrequest  in  1  stall
- pix_valid  out  1  pixel available
- pix_ready  in  1  consumer accepts pixel
- pix_data  out  BPP  pixel value

## Operation
- Registers: 0 S_ADDR (base byte address), 1 LENGTH (words per frame, 32 bits), 2 CONTROL (bit0 RUN, bit1 CONT, bit2 IE), 3 STATUS (bit0 BUSY ro, bit1 DONE sticky, write 1 clears), 4 FILL (ro, FIFO word count), 5–7 read 0, writes ignored.
- Writing CONTROL with bit0=1 while IDLE starts a frame; writing bit0=0 requests stop. S_ADDR/LENGTH are latched into working pointer/counter at start; writes to them mid-frame affect the next frame only.
- FSM: IDLE → REQ (RUN set, LENGTH≠0) ; REQ asserts avm_read_read while FIFO count < FIFO_DEPTH; on read && !waitrequest push word, address += DATA_W/8, remaining −1; remaining reaches 0 → DRAIN. DRAIN waits for FIFO and unpacker empty, sets DONE, then: CONT && RUN → reload S_ADDR/LENGTH → REQ; else clear RUN → IDLE.
- LENGTH=0 start: DONE set next cycle, no master traffic, RUN cleared.
- Stop request (RUN cleared) in REQ: finish any request already asserted, go to DRAIN, DONE not set, then IDLE.
- Unpacker: pops a word, emits DATA_W/BPP pixels LSB-first; pix_data holds while pix_valid && !pix_ready.
- Address arithmetic wraps modulo 2^ADDR_W; remaining counter is 32-bit.

## Timing
- Reset: avm_read_read 0, avm_read_address 0, pix_valid 0, pix_data 0, avs_s1_irq 0, avs_s1_readdata 0, all registers 0, FIFO empty, FSM IDLE.
- Register reads combinational from address (zero wait); writes take effect on the strobe edge.
- First avm_read_read asserted the cycle after the starting CONTROL write.
- avm_read_address/read held stable while waitrequest=1.
- Word accepted at cycle N is visible on pix_data at N+2 if FIFO was empty.
- Sustained output: one pixel per clock with pix_ready=1 when memory returns words without wait.
- FIFO push and pop in the same cycle at full: allowed, count unchanged. Request never issued when count = FIFO_DEPTH.
- Reset mid-frame: all state returns to reset values on that edge; in-flight request dropped.

## Configuration
- VGA_FRAME_IRQ_EN defined: avs_s1_irq = DONE && CONTROL.IE, cleared by writing 1 to STATUS bit1.
- Undefined: avs_s1_irq tied 0; CONTROL bit2 reads 0; DONE still set and polled.

## Test plan
- S_ADDR=0x900000, LENGTH=200, CONTROL=1, DATA_W=16, BPP=1, no waitrequest → 200 reads, addresses 0x900000..0x90018E step 2, 3200 pixels LSB-first, DONE=1, BUSY=0.
- BPP=4, word 0x3A5C → pix_data sequence C,5,A,3.
- pix_ready=0 held with LENGTH=64, FIFO_DEPTH=16 → exactly 16 reads (+1 held in unpacker), avm_read_read deasserted, FILL=16.
- waitrequest high 5 cycles per read → address/read stable through stall, data sequence intact.
- CONT=1, LENGTH=4 → address returns to S_ADDR after 4 words, DONE set each frame; clear RUN mid-frame → drains, IDLE, DONE not set.
- VGA_FRAME_IRQ_EN, IE=1: frame end → irq=1; write STATUS=2 → irq=0 next cycle; LENGTH=0 start → irq without master reads.
